fetch_unit: RTL and testbench

- Instruction-fetch front end of the 4-bit-opcode core: holds the PC, issues one-outstanding requests to instruction memory and buffers returned words in a small FIFO.
- Presents decoded instruction fields (opcode, imm flag, register indices, immediate) to the decode/control stage over a valid/ready handshake.
- Flushes on branch/jump redirect from execute.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 4-bit-opcode core front end:
//   - instruction width and field bit positions
//   - opcode enumeration (0xC..0xF are undefined and treated as NOP downstream)
//   - fetch FSM state encoding
//   - helper that sign-extends the 19-bit immediate field
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W  = 32;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 28;
    localparam int IMM_BIT  = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 23;
    localparam int RN_HI    = 22;
    localparam int RN_LO    = 19;
    localparam int RM_HI    = 18;
    localparam int RM_LO    = 15;
    localparam int IMMVAL_W = 19;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_ORR = 4'd3,
        OP_LSL = 4'd4,
        OP_CMP = 4'd5,
        OP_SET = 4'd6,
        OP_LDR = 4'd7,
        OP_STR = 4'd8,
        OP_B   = 4'd9,
        OP_BEQ = 4'd10,
        OP_BGE = 4'd11
    } opcode_e;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_WAIT  = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sext_immval(input logic [INSTR_W-1:0] instr);
        return {{(32-IMMVAL_W){instr[IMMVAL_W-1]}}, instr[IMMVAL_W-1:0]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding {pc, instr} entries for the fetch unit.
// Write is registered; the head entry is read combinationally so the decode
// stage sees it in the cycle after the push.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push/push_data  write one entry (ignored when full without a same-cycle pop)
//   pop             remove the head entry (ignored when empty)
//   flush           empty the FIFO; overrides push and pop
//   head_data       current head entry (undefined when count == 0)
//   count           current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = pop && (r_count != '0);
    // A pop in the same cycle frees the slot, so a push at full is legal then.
    assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage carries no reset; occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end: holds the PC, keeps at most one request to
// instruction memory outstanding, buffers returned words in fetch_fifo and
// presents decoded fields to decode over a valid/ready handshake. A redirect
// from execute flushes the buffer and restarts fetch at redirect_pc.
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_flushed.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req, imem_addr           request pulse and fetch address
//   imem_valid, imem_rdata        memory response
//   redirect, redirect_pc         branch/jump restart
//   id_valid, id_ready            head-of-buffer handshake to decode
//   id_pc, id_opcode, id_imm,
//   id_rd, id_rn, id_rm, id_immval decoded head fields (0 while id_valid=0)
//   perf_fetched, perf_flushed    (FETCH_PERF_EN only) event counters
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_valid,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 redirect,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [ADDR_W-1:0]    id_pc,
    output logic [3:0]           id_opcode,
    output logic                 id_imm,
    output logic [3:0]           id_rd,
    output logic [3:0]           id_rn,
    output logic [3:0]           id_rm,
    output logic [31:0]          id_immval
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_flushed
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e               r_state;
    fetch_state_e               w_state_next;
    logic [ADDR_W-1:0]          r_pc;
    logic [ADDR_W-1:0]          w_pc_inc;
    logic [CNT_W-1:0]           w_count;
    logic [CNT_W-1:0]           w_cnt_after;
    logic [ADDR_W+INSTR_W-1:0]  w_head;
    logic [INSTR_W-1:0]         w_instr;
    logic                       w_resp;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_space;
    logic                       w_req;

    assign w_pc_inc = r_pc + ADDR_W'(4);
    assign w_resp   = (r_state == FS_WAIT) && imem_valid;
    assign w_push   = w_resp && !redirect;
    assign w_pop    = id_valid && id_ready;

    // Occupancy once this cycle's push/pop land; decides back-to-back fetch.
    assign w_cnt_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_space     = w_cnt_after < CNT_W'(FIFO_DEPTH);

    // The response cycle re-issues immediately so a 1-cycle memory sustains
    // one instruction per cycle; the address is then the advanced PC.
    assign w_req = !rst && !redirect &&
                   (((r_state == FS_IDLE) && (w_count < CNT_W'(FIFO_DEPTH))) ||
                    (w_resp && w_space));

    assign imem_req  = w_req;
    assign imem_addr = w_resp ? w_pc_inc : r_pc;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FS_IDLE: begin
                if (w_req) begin
                    w_state_next = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (redirect) begin
                    w_state_next = imem_valid ? FS_IDLE : FS_DRAIN;
                end else if (imem_valid) begin
                    w_state_next = w_space ? FS_WAIT : FS_IDLE;
                end
            end
            FS_DRAIN: begin
                // The stale response ends the drain even if another redirect
                // arrives with it; nothing else is outstanding.
                if (imem_valid) begin
                    w_state_next = FS_IDLE;
                end
            end
            default: w_state_next = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FS_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_push) begin
                r_pc <= w_pc_inc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({r_pc, imem_rdata}),
        .pop       (w_pop),
        .flush     (redirect),
        .head_data (w_head),
        .count     (w_count)
    );

    assign id_valid  = (w_count != '0);
    assign w_instr   = id_valid ? w_head[INSTR_W-1:0] : '0;
    assign id_pc     = id_valid ? w_head[ADDR_W+INSTR_W-1:INSTR_W] : '0;
    assign id_opcode = w_instr[OPC_HI:OPC_LO];
    assign id_imm    = w_instr[IMM_BIT];
    assign id_rd     = w_instr[RD_HI:RD_LO];
    assign id_rn     = w_instr[RN_HI:RN_LO];
    assign id_rm     = w_instr[RM_HI:RM_LO];
    assign id_immval = sext_immval(w_instr);

`ifdef FETCH_PERF_EN
    logic w_discard;

    // A response is thrown away when it meets a redirect in WAIT or arrives
    // while draining.
    assign w_discard = imem_valid && (((r_state == FS_WAIT) && redirect) ||
                                      (r_state == FS_DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (w_push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            // An entry popped in the redirect cycle was consumed, not flushed.
            if (redirect) begin
                perf_flushed <= perf_flushed + 32'(w_count) - 32'(w_pop) + 32'(w_discard);
            end else if (w_discard) begin
                perf_flushed <= perf_flushed + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [3:0]  id_opcode;
    logic        id_imm;
    logic [3:0]  id_rd;
    logic [3:0]  id_rn;
    logic [3:0]  id_rm;
    logic [31:0] id_immval;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_opcode   (id_opcode),
        .id_imm      (id_imm),
        .id_rd       (id_rd),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_immval   (id_immval)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_log[$];
    logic [31:0] resp_addr;
    logic [31:0] first_pop_pc;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          n_req = 0;
    int          n_pop = 0;
    bit          drain = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'h5C0A_4005;
            32'h0000_0204: return 32'h0804_0000;
            default:       return 32'h0080_0000 | {17'd0, a[16:2]};
        endcase
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: answers each request 'lat' cycles later.
    initial begin
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        resp_addr  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                imem_valid = 1'b0;
                imem_rdata = 32'h0;
            end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                resp_addr  = pend_addr.pop_front();
                void'(pend_due.pop_front());
                imem_valid = 1'b1;
                imem_rdata = mem_word(resp_addr);
                $display("resp  addr=%h data=%h", resp_addr, imem_rdata);
            end else begin
                imem_valid = 1'b0;
                imem_rdata = 32'h0;
            end
        end
    end

    // Monitor / scoreboard: checks the head against the expected queue every
    // cycle, pops on handshake, then folds this cycle's inputs into the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                drain = 0;
            end else begin
                check("id_valid", {31'd0, id_valid}, {31'd0, exp_q.size() != 0});
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("id_pc",     id_pc,               e.pc);
                    check("id_opcode", {28'd0, id_opcode},  {28'd0, e.instr[31:28]});
                    check("id_imm",    {31'd0, id_imm},     {31'd0, e.instr[27]});
                    check("id_rd",     {28'd0, id_rd},      {28'd0, e.instr[26:23]});
                    check("id_rn",     {28'd0, id_rn},      {28'd0, e.instr[22:19]});
                    check("id_rm",     {28'd0, id_rm},      {28'd0, e.instr[18:15]});
                    check("id_immval", id_immval,           {{13{e.instr[18]}}, e.instr[18:0]});
                    if (id_ready) begin
                        void'(exp_q.pop_front());
                        if (n_pop == 0) first_pop_pc = e.pc;
                        n_pop++;
                        $display("pop   pc=%h instr=%h", e.pc, e.instr);
                    end
                end else begin
                    check("id_pc_idle", id_pc, 32'h0);
                end
                if (redirect) begin
                    exp_q.delete();
                    if (imem_valid) drain = 0;
                    else if (pend_addr.size() != 0) drain = 1;
                end else if (imem_valid) begin
                    if (drain) drain = 0;
                    else exp_q.push_back('{resp_addr, imem_rdata});
                end
                if (imem_req) begin
                    pend_addr.push_back(imem_addr);
                    pend_due.push_back(cyc + lat);
                    req_log.push_back(imem_addr);
                    n_req++;
                    $display("req   addr=%h", imem_addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        tick();
        tick();
        req_log.delete();
        n_req = 0;
        n_pop = 0;
        first_pop_pc = 32'hFFFF_FFFF;
    endtask

    initial begin
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;

        // Reset values
        tick();
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr,         32'h0);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_pc",    id_pc,             32'h0);
        check("rst_immval", id_immval,        32'h0);

        // Streaming at one instruction per cycle
        hold_reset();
        lat = 1; id_ready = 1'b1;
        rst = 1'b0;
        repeat (3) tick();
        check("s_opcode", {28'd0, id_opcode}, 32'd0);
        check("s_rd",     {28'd0, id_rd},     32'd1);
        check("s_pc",     id_pc,              32'h4);
        repeat (9) tick();
        check("s_npop", n_pop, 10);
        check("s_nreq", n_req, 12);
        check("s_a0", log_at(0), 32'h0);
        check("s_a1", log_at(1), 32'h4);
        check("s_a2", log_at(2), 32'h8);
        check("s_a3", log_at(3), 32'hC);

        // Decode stalled: buffer fills with two entries, then fetch stops
        hold_reset();
        lat = 1; id_ready = 1'b0;
        rst = 1'b0;
        repeat (5) tick();
        check("st_nreq",  n_req, 2);
        check("st_a1",    log_at(1), 32'h4);
        check("st_valid", {31'd0, id_valid}, 32'd1);
        check("st_pc",    id_pc, 32'h0);
        id_ready = 1'b1;
        tick();
        check("st_nreq_pop", n_req, 2);
        tick();
        check("st_nreq_after", n_req, 3);
        check("st_a2", log_at(2), 32'h8);
        repeat (6) tick();

        // Redirect in WAIT, stale response two cycles later
        hold_reset();
        lat = 3; id_ready = 1'b1;
        rst = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("rw_valid", {31'd0, id_valid}, 32'd0);
        tick();
        check("rw_drain_req", {31'd0, imem_req}, 32'd0);
        lat = 1;
        repeat (8) tick();
        check("rw_a0", log_at(0), 32'h0);
        check("rw_a1", log_at(1), 32'h100);
        check("rw_first", first_pop_pc, 32'h100);

        // Redirect together with a response and a pop
        hold_reset();
        lat = 1; id_ready = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 32'h300;
        #1;
        check("rv_req_gated", {31'd0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("rv_valid", {31'd0, id_valid}, 32'd0);
        check("rv_req",   {31'd0, imem_req}, 32'd1);
        check("rv_addr",  imem_addr, 32'h300);
        check("rv_npop",  n_pop, 1);
        repeat (6) tick();

        // Field extraction on hand-picked words
        hold_reset();
        lat = 1; id_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h200;
        rst = 1'b0;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        check("f0_pc",     id_pc, 32'h200);
        check("f0_opcode", {28'd0, id_opcode}, 32'd5);
        check("f0_imm",    {31'd0, id_imm},    32'd1);
        check("f0_rd",     {28'd0, id_rd},     32'd8);
        check("f0_rn",     {28'd0, id_rn},     32'd1);
        check("f0_rm",     {28'd0, id_rm},     32'd4);
        check("f0_immval", id_immval, 32'h0002_4005);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        tick();
        check("f1_pc",     id_pc, 32'h204);
        check("f1_opcode", {28'd0, id_opcode}, 32'd0);
        check("f1_imm",    {31'd0, id_imm},    32'd1);
        check("f1_rd",     {28'd0, id_rd},     32'd0);
        check("f1_rm",     {28'd0, id_rm},     32'd8);
        check("f1_immval", id_immval, 32'hFFFC_0000);
        id_ready = 1'b1;
        repeat (4) tick();

        // PC wrap at the top of the address space
        hold_reset();
        lat = 1; id_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        rst = 1'b0;
        tick();
        redirect = 1'b0;
        repeat (6) tick();
        check("w_a0", log_at(0), 32'hFFFF_FFF8);
        check("w_a1", log_at(1), 32'hFFFF_FFFC);
        check("w_a2", log_at(2), 32'h0000_0000);

        // Asynchronous reset in the middle of WAIT with a buffered entry
        hold_reset();
        lat = 2; id_ready = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check("ar_pre_valid", {31'd0, id_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("ar_req",   {31'd0, imem_req}, 32'd0);
        check("ar_addr",  imem_addr, 32'h0);
        check("ar_valid", {31'd0, id_valid}, 32'd0);
        check("ar_pc",    id_pc, 32'h0);
        check("ar_rd",    {28'd0, id_rd}, 32'd0);
        tick();
        lat = 1; id_ready = 1'b1;
        rst = 1'b0;
        repeat (5) tick();
        check("ar_restart_npop", n_pop, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
